// File: rtl/secuenciador_muestreo_pkg.sv
// Shared types for the monitoring datapath: state codes and widths.
// No ports; imported by the sequencer, its interface and sub-modules.
package pkg_monitor;

    typedef enum logic [1:0] {
        REPOSO   = 2'b00,
        CAPTURA  = 2'b01,
        DECISION = 2'b10,
        ESPERA   = 2'b11
    } estado_t;

    localparam int ANCHO_TEMP_DEF = 5;
    localparam int ANCHO_MUESTRAS = 8;

endpackage

// File: rtl/secuenciador_muestreo_if.sv
// Snapshot + 4-phase request/ack bundle towards the decision logic.
// master: sequencer (drives snapshot/request); slave: decision logic.
interface secuenciador_muestreo_if #(
    parameter int ANCHO_TEMP = 5
) ();

    logic [ANCHO_TEMP-1:0] Temperatura_out;
    logic                  Presencia_out;
    logic                  Ignicion_out;
    logic                  Activar_Decidir;
    logic                  Ack_decision;

    modport master (
        output Temperatura_out,
        output Presencia_out,
        output Ignicion_out,
        output Activar_Decidir,
        input  Ack_decision
    );

    modport slave (
        input  Temperatura_out,
        input  Presencia_out,
        input  Ignicion_out,
        input  Activar_Decidir,
        output Ack_decision
    );

endinterface

// File: rtl/secuenciador_muestreo_contador.sv
// Period counter: counts while en, sync clear, tc at TICKS-1.
// Ports: clk, rst (sync active-low), en, clr in; tc out.
module contador_periodo #(
    parameter int TICKS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int W = $clog2(TICKS);

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(TICKS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            // Wrap keeps the count in range even if the
            // capture that follows a tick is delayed.
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/secuenciador_muestreo.sv
// Sample/decision sequencer: periodic or event capture + 4-phase
// handshake with timeout. Ports: clk, rst, Dato_listo, *_in, dec
// (snapshot/handshake bundle), Error_timeout, Estados, Contador_muestras.
module secuenciador_muestreo
    import pkg_monitor::*;
#(
    parameter int TICKS_PERIODO = 1000,
    parameter int TIMEOUT       = 16,
    parameter int ANCHO_TEMP    = ANCHO_TEMP_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Dato_listo,
    input  logic [ANCHO_TEMP-1:0]     Temperatura_in,
    input  logic                      Presencia_in,
    input  logic                      Ignicion_in,
    secuenciador_muestreo_if.master   dec,
    output logic                      Error_timeout,
    output logic [1:0]                Estados,
    output logic [ANCHO_MUESTRAS-1:0] Contador_muestras
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    estado_t                   estado;
    logic                      pendiente;
    logic [TW-1:0]             cnt_to;
    logic                      tc;
    logic [ANCHO_TEMP-1:0]     temp_q;
    logic                      pres_q;
    logic                      ign_q;
    logic                      activar_q;
    logic                      error_q;
    logic [ANCHO_MUESTRAS-1:0] muestras_q;

    contador_periodo #(
        .TICKS (TICKS_PERIODO)
    ) u_periodo (
        .clk (clk),
        .rst (rst),
        .en  (estado == REPOSO),
        .clr (estado == CAPTURA),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado     <= REPOSO;
            pendiente  <= 1'b0;
            cnt_to     <= '0;
            temp_q     <= '0;
            pres_q     <= 1'b0;
            ign_q      <= 1'b0;
            activar_q  <= 1'b0;
            error_q    <= 1'b0;
            muestras_q <= '0;
        end else begin
            unique case (estado)
                REPOSO: begin
                    if (tc || Dato_listo || pendiente)
                        estado <= CAPTURA;
                end
                CAPTURA: begin
                    temp_q     <= Temperatura_in;
                    pres_q     <= Presencia_in;
                    ign_q      <= Ignicion_in;
                    muestras_q <= muestras_q + 1'b1;
                    cnt_to     <= '0;
                    activar_q  <= 1'b1;
                    // An event landing on the capture edge itself
                    // must still trigger the following cycle.
                    pendiente  <= Dato_listo;
                    estado     <= DECISION;
                end
                DECISION: begin
                    if (Dato_listo)
                        pendiente <= 1'b1;
                    // Ack has priority over an expiring timeout.
                    if (dec.Ack_decision) begin
                        activar_q <= 1'b0;
                        error_q   <= 1'b0;
                        estado    <= ESPERA;
                    end else if (cnt_to == TW'(TIMEOUT - 1)) begin
                        activar_q <= 1'b0;
                        error_q   <= 1'b1;
                        estado    <= ESPERA;
                    end else begin
                        cnt_to <= cnt_to + 1'b1;
                    end
                end
                ESPERA: begin
                    if (Dato_listo)
                        pendiente <= 1'b1;
                    if (!dec.Ack_decision)
                        estado <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end

    assign dec.Temperatura_out = temp_q;
    assign dec.Presencia_out   = pres_q;
    assign dec.Ignicion_out    = ign_q;
    assign dec.Activar_Decidir = activar_q;
    assign Error_timeout       = error_q;
    assign Estados             = estado;
    assign Contador_muestras   = muestras_q;

endmodule

// File: tb/tb_secuenciador_muestreo.sv
// Directed bench for secuenciador_muestreo (TICKS_PERIODO=8, TIMEOUT=4).
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_secuenciador_muestreo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dl  = 1'b0;
    logic [4:0] temp_in = '0;
    logic       pres_in = 1'b0;
    logic       ign_in  = 1'b0;
    logic       err;
    logic [1:0] est;
    logic [7:0] cnt;

    int n_cmp = 0;
    int n_err = 0;

    secuenciador_muestreo_if #(.ANCHO_TEMP(5)) dec ();

    secuenciador_muestreo #(
        .TICKS_PERIODO (8),
        .TIMEOUT       (4),
        .ANCHO_TEMP    (5)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .Dato_listo        (dl),
        .Temperatura_in    (temp_in),
        .Presencia_in      (pres_in),
        .Ignicion_in       (ign_in),
        .dec               (dec),
        .Error_timeout     (err),
        .Estados           (est),
        .Contador_muestras (cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        dl = 1'b0;
        temp_in = '0;
        pres_in = 1'b0;
        ign_in = 1'b0;
        dec.Ack_decision = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        dl = 1'b1;
        temp_in = 5'd31;
        pres_in = 1'b1;
        ign_in = 1'b1;
        dec.Ack_decision = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (dec.Temperatura_out !== 5'd0 || dec.Presencia_out !== 1'b0
            || dec.Ignicion_out !== 1'b0) begin
            n_err++;
            $display("FAIL rst_snapshot: got %0d/%0d/%0d want 0/0/0",
                     dec.Temperatura_out, dec.Presencia_out,
                     dec.Ignicion_out);
        end
        n_cmp++;
        if (dec.Activar_Decidir !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_flags: act=%0b err=%0b want 0/0",
                     dec.Activar_Decidir, err);
        end
        n_cmp++;
        if (est !== 2'b00 || cnt !== 8'd0) begin
            n_err++;
            $display("FAIL rst_state: est=%0d cnt=%0d want 0/0", est, cnt);
        end
        dl = 1'b0;
        temp_in = '0;
        pres_in = 1'b0;
        ign_in = 1'b0;
        dec.Ack_decision = 1'b0;
        rst = 1'b1;
        repeat (7) step();
        n_cmp++;
        if (est !== 2'b00) begin
            n_err++;
            $display("FAIL tick_early: est=%0d want 0 after 7", est);
        end
        step();
        n_cmp++;
        if (est !== 2'b01) begin
            n_err++;
            $display("FAIL tick_8th: est=%0d want 1 after 8", est);
        end
    endtask

    task automatic test_change_handshake();
        do_reset();
        temp_in = 5'd23;
        pres_in = 1'b1;
        dl = 1'b1;
        step();
        dl = 1'b0;
        n_cmp++;
        if (est !== 2'b01) begin
            n_err++;
            $display("FAIL chg_captura: est=%0d want 1", est);
        end
        step();
        n_cmp++;
        if (dec.Temperatura_out !== 5'd23 || dec.Presencia_out !== 1'b1
            || dec.Activar_Decidir !== 1'b1 || est !== 2'b10) begin
            n_err++;
            $display("FAIL chg_decision: t=%0d p=%0b act=%0b est=%0d want 23/1/1/2",
                     dec.Temperatura_out, dec.Presencia_out,
                     dec.Activar_Decidir, est);
        end
        step();
        step();
        dec.Ack_decision = 1'b1;
        n_cmp++;
        if (dec.Activar_Decidir !== 1'b1) begin
            n_err++;
            $display("FAIL chg_hold_act: act=%0b want 1",
                     dec.Activar_Decidir);
        end
        step();
        n_cmp++;
        if (dec.Activar_Decidir !== 1'b0 || est !== 2'b11 || err !== 1'b0)
        begin
            n_err++;
            $display("FAIL chg_ack: act=%0b est=%0d err=%0b want 0/3/0",
                     dec.Activar_Decidir, est, err);
        end
        step();
        dec.Ack_decision = 1'b0;
        n_cmp++;
        if (est !== 2'b11) begin
            n_err++;
            $display("FAIL chg_espera: est=%0d want 3", est);
        end
        step();
        n_cmp++;
        if (est !== 2'b00 || cnt !== 8'd1) begin
            n_err++;
            $display("FAIL chg_end: est=%0d cnt=%0d want 0/1", est, cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        dl = 1'b1;
        step();
        dl = 1'b0;
        step();
        n_cmp++;
        if (dec.Activar_Decidir !== 1'b1) begin
            n_err++;
            $display("FAIL to_rise: act=%0b want 1", dec.Activar_Decidir);
        end
        for (int i = 1; i < 4; i++) begin
            step();
            n_cmp++;
            if (est !== 2'b10 || err !== 1'b0) begin
                n_err++;
                $display("FAIL to_wait%0d: est=%0d err=%0b want 2/0",
                         i, est, err);
            end
        end
        step();
        n_cmp++;
        if (est !== 2'b11 || err !== 1'b1 || dec.Activar_Decidir !== 1'b0)
        begin
            n_err++;
            $display("FAIL to_fire: est=%0d err=%0b act=%0b want 3/1/0",
                     est, err, dec.Activar_Decidir);
        end
        step();
        n_cmp++;
        if (est !== 2'b00) begin
            n_err++;
            $display("FAIL to_reposo: est=%0d want 0", est);
        end
        dl = 1'b1;
        step();
        dl = 1'b0;
        step();
        n_cmp++;
        if (err !== 1'b1 || est !== 2'b10) begin
            n_err++;
            $display("FAIL to_sticky: err=%0b est=%0d want 1/2", err, est);
        end
        dec.Ack_decision = 1'b1;
        step();
        dec.Ack_decision = 1'b0;
        n_cmp++;
        if (err !== 1'b0 || est !== 2'b11) begin
            n_err++;
            $display("FAIL to_clear: err=%0b est=%0d want 0/3", err, est);
        end
        step();
    endtask

    task automatic test_mid_cycle();
        do_reset();
        temp_in = 5'd23;
        dl = 1'b1;
        step();
        dl = 1'b0;
        step();
        temp_in = 5'd30;
        dl = 1'b1;
        step();
        dl = 1'b0;
        n_cmp++;
        if (dec.Temperatura_out !== 5'd23 || est !== 2'b10) begin
            n_err++;
            $display("FAIL mid_hold: t=%0d est=%0d want 23/2",
                     dec.Temperatura_out, est);
        end
        dec.Ack_decision = 1'b1;
        step();
        dec.Ack_decision = 1'b0;
        step();
        n_cmp++;
        if (dec.Temperatura_out !== 5'd23 || est !== 2'b00) begin
            n_err++;
            $display("FAIL mid_reposo: t=%0d est=%0d want 23/0",
                     dec.Temperatura_out, est);
        end
        step();
        n_cmp++;
        if (est !== 2'b01) begin
            n_err++;
            $display("FAIL mid_pending: est=%0d want 1", est);
        end
        step();
        n_cmp++;
        if (dec.Temperatura_out !== 5'd30 || cnt !== 8'd2) begin
            n_err++;
            $display("FAIL mid_second: t=%0d cnt=%0d want 30/2",
                     dec.Temperatura_out, cnt);
        end
    endtask

    task automatic test_tick_and_reset();
        do_reset();
        repeat (7) step();
        dl = 1'b1;
        step();
        dl = 1'b0;
        n_cmp++;
        if (est !== 2'b01) begin
            n_err++;
            $display("FAIL tick_dl_cap: est=%0d want 1", est);
        end
        repeat (7) step();
        n_cmp++;
        if (est !== 2'b00 || cnt !== 8'd1) begin
            n_err++;
            $display("FAIL tick_dl_once: est=%0d cnt=%0d want 0/1",
                     est, cnt);
        end
        dl = 1'b1;
        step();
        dl = 1'b0;
        step();
        n_cmp++;
        if (dec.Activar_Decidir !== 1'b1 || err !== 1'b1) begin
            n_err++;
            $display("FAIL rstdec_pre: act=%0b err=%0b want 1/1",
                     dec.Activar_Decidir, err);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_cmp++;
        if (dec.Activar_Decidir !== 1'b0 || est !== 2'b00
            || err !== 1'b0 || cnt !== 8'd0) begin
            n_err++;
            $display("FAIL rstdec_post: act=%0b est=%0d err=%0b cnt=%0d want 0/0/0/0",
                     dec.Activar_Decidir, est, err, cnt);
        end
    endtask

    task automatic test_wrap();
        int caps;
        do_reset();
        caps = 0;
        dl = 1'b1;
        for (int i = 0; i < 5000 && caps < 256; i++) begin
            step();
            if (est == 2'b01)
                caps++;
        end
        n_cmp++;
        if (caps !== 256 || cnt !== 8'd255) begin
            n_err++;
            $display("FAIL wrap_pre: caps=%0d cnt=%0d want 256/255",
                     caps, cnt);
        end
        dl = 1'b0;
        step();
        n_cmp++;
        if (cnt !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_zero: cnt=%0d want 0", cnt);
        end
    endtask

    initial begin
        dec.Ack_decision = 1'b0;
        test_reset();
        test_change_handshake();
        test_timeout();
        test_mid_cycle();
        test_tick_and_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/secuenciador_muestreo.md
# secuenciador_muestreo

Sequencer for the temperature/presence/ignition monitoring datapath. Starts a sample/decision cycle periodically or on a debounced input change. Each cycle freezes a coherent snapshot of the synchronized inputs and runs a 4-phase handshake with the decision logic. It sits between the anti-bounce register bank and the activation/danger logic, and supervises the handshake with a timeout.

## Interface

Parameters:
- TICKS_PERIODO, default 1000 — clk cycles between periodic samples; minimum 2.
- TIMEOUT, default 16 — cycles allowed for Ack_decision; minimum 1.
- ANCHO_TEMP, default 5 — temperature width.

Ports:
- clk  in  1 — single system clock, all logic on rising edge.
- rst  in  1 — synchronous, active-low reset.
- Dato_listo  in  1 — OR of all debouncer ready flags; 1-cycle or level.
- Temperatura_in  in  ANCHO_TEMP — synchronized temperature.
- Presencia_in  in  1 — synchronized presence.
- Ignicion_in  in  1 — synchronized ignition.
- Ack_decision  in  1 — decision logic acknowledge (4-phase).
- Temperatura_out  out  ANCHO_TEMP — snapshot temperature.
- Presencia_out  out  1 — snapshot presence.
- Ignicion_out  out  1 — snapshot ignition.
- Activar_Decidir  out  1 — request to decision logic.
- Error_timeout  out  1 — sticky handshake-timeout flag.
- Estados  out  2 — current state code.
- Contador_muestras  out  8 — completed captures, modulo 256.

## Operation

- States, with their Estados codes:
  - REPOSO 00
  - CAPTURA 01
  - DECISION 10
  - ESPERA 11
- REPOSO:
  - Period counter increments every cycle.
  - Goes to CAPTURA when the counter equals TICKS_PERIODO-1, or Dato_listo=1, or the pending flag is set.
- CAPTURA (exactly one cycle):
  - Registers Temperatura_in/Presencia_in/Ignicion_in into the snapshot outputs.
  - Increments Contador_muestras, wrapping 255→0.
  - Clears the period counter and the pending flag.
  - Goes to DECISION.
- DECISION:
  - Activar_Decidir=1 and the snapshot is held stable.
  - Ack_decision=1 → ESPERA; Error_timeout is cleared.
  - No ack for TIMEOUT cycles → ESPERA; Error_timeout is set.
- ESPERA:
  - Activar_Decidir=0.
  - Stays until Ack_decision=0, then goes to REPOSO.
  - Minimum dwell is one cycle.
- Pending flag: Dato_listo=1 in any state other than REPOSO sets the flag. This ensures a change arriving mid-cycle is sampled in the next cycle. Multiple events collapse into one pending capture.
- Snapshot outputs change only in CAPTURA.
- Period counter:
  - Holds its value outside REPOSO.
  - Cleared only in CAPTURA, so a periodic tick is never counted twice.

## Timing

- Reset (rst=0 at an edge):
  - State REPOSO; period, timeout and sample counters cleared; pending cleared.
  - All outputs 0, Estados=00.
  - Overrides any in-progress cycle; Activar_Decidir drops the cycle after reset.
- Dato_listo=1 at edge n in REPOSO:
  - Estados=01 during n+1.
  - Snapshot visible and Activar_Decidir=1 from n+2.
- Ack_decision=1 sampled at edge m in DECISION: Activar_Decidir=0 and Estados=11 from m+1.
- Timeout: DECISION entered at edge t with no ack → at edge t+TIMEOUT, Estados=11 and Error_timeout=1.
- Ack and timeout in the same cycle: ack wins; Error_timeout is cleared.
- Periodic tick and Dato_listo in the same cycle: one capture only; pending is not set.
- Ack already low on entering ESPERA (timeout path): REPOSO one cycle later.
- Ack that never deasserts: the block stays in ESPERA with no timeout there. This is intentional; the decision logic must complete the handshake.

## Structure

- Shared package `pkg_monitor`:
  - State codes REPOSO/CAPTURA/DECISION/ESPERA (2-bit).
  - ANCHO_TEMP default.
  - Sample-counter width (8).
- Natural sub-module: `contador_periodo` — period counter with enable (active in REPOSO), synchronous clear and terminal-count output at TICKS_PERIODO-1.
- FSM, pending flag, timeout counter and snapshot registers live in the top module.

## Test plan

- Reset behaviour:
  - Stimulus: hold rst=0 for 3 cycles with all inputs 1.
  - Required: all outputs 0, Estados=00.
  - Then: release with idle inputs, TICKS_PERIODO=8. Required: first CAPTURA on the 8th cycle after release.
- Change-triggered cycle with handshake:
  - Stimulus: Temperatura_in=5'd23, 1-cycle Dato_listo pulse at n; Ack_decision=1 at n+4, Ack_decision=0 at n+6.
  - Required: Temperatura_out=23 and Activar_Decidir=1 from n+2; Activar_Decidir=0 from n+5; Estados=00 at n+7; Contador_muestras=1.
- Handshake timeout:
  - Stimulus: TIMEOUT=4, never ack.
  - Required: Error_timeout=1 exactly 4 cycles after Activar_Decidir rises.
  - Then: next cycle acked. Required: Error_timeout clears the cycle after the ack.
- Mid-cycle event:
  - Stimulus: Dato_listo pulses during DECISION while Temperatura_in changes 23→30.
  - Required: snapshot stays 23 until the cycle ends; a second capture of 30 follows immediately after ESPERA→REPOSO.
- Simultaneous tick and reset:
  - Stimulus: periodic tick coincident with Dato_listo.
  - Required: exactly one increment of Contador_muestras.
  - Stimulus: rst=0 asserted in DECISION.
  - Required: Activar_Decidir=0 and Estados=00 the next cycle.
- Wrap-around:
  - Stimulus: 256 completed captures.
  - Required: Contador_muestras returns to 0.
